// File: rtl/alu_iq_issue_ctrl.sv
// rtl/alu_iq_issue_ctrl.sv - ALU issue queue head issue controller (optional feature macro: ISSUE_WB_BYPASS_EN)

module alu_iq_issue_ctrl #(
    parameter int MUL_LAT       = 3,
    parameter int NUM_ARCH_REGS = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       head_valid,
    input  logic [1:0] head_exu_type,
    input  logic       head_has_rd,
    input  logic       head_has_rs1,
    input  logic       head_has_rs2,
    input  logic [4:0] head_rd,
    input  logic [4:0] head_rs1,
    input  logic [4:0] head_rs2,
    output logic       deq,
    output logic       alu_issue,
    output logic       mul_issue,
    output logic       div_issue,
    output logic       wb_port_valid,
    output logic       wb_port_is_mul,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd,
    input  logic       div_wb_valid,
    input  logic [4:0] div_wb_rd,
    output logic       err_bad_type
);

    // exe_unit_type_t encoding
    localparam logic [1:0] EXU_ALU = 2'd0;
    localparam logic [1:0] EXU_MUL = 2'd1;
    localparam logic [1:0] EXU_DIV = 2'd2;
    localparam logic [1:0] EXU_MEM = 2'd3;

    logic [NUM_ARCH_REGS-1:0] busy_q, busy_d;
    logic [MUL_LAT:0]         resv_q, resv_d;
    logic [MUL_LAT:0]         resv_type_q, resv_type_d;
    logic                     div_busy_q, div_busy_d;
    logic                     err_bad_type_q, err_bad_type_d;

    logic [NUM_ARCH_REGS-1:0] clr_mask;
    logic [NUM_ARCH_REGS-1:0] byp_mask;
    logic                     rs1_ok, rs2_ok, waw_ok, unit_ok, can_issue;

    // Registers being released this cycle by either writeback port
    always_comb begin
        clr_mask = '0;
        if (wb_valid) begin
            clr_mask[wb_rd] = 1'b1;
        end
        if (div_wb_valid) begin
            clr_mask[div_wb_rd] = 1'b1;
        end
    end

`ifdef ISSUE_WB_BYPASS_EN
    assign byp_mask = clr_mask;
`else
    assign byp_mask = '0;
`endif

    // Hazard, structural and issue decision for the queue head
    always_comb begin
        rs1_ok = !head_has_rs1 || (head_rs1 == 5'd0) || !busy_q[head_rs1] || byp_mask[head_rs1];
        rs2_ok = !head_has_rs2 || (head_rs2 == 5'd0) || !busy_q[head_rs2] || byp_mask[head_rs2];
        waw_ok = !head_has_rd  || (head_rd  == 5'd0) || !busy_q[head_rd]  || byp_mask[head_rd];
        unit_ok = 1'b0;
        case (head_exu_type)
            EXU_ALU: unit_ok = !resv_q[1];
            EXU_MUL: unit_ok = !resv_q[MUL_LAT];
            EXU_DIV: unit_ok = !div_busy_q || div_wb_valid;
            default: unit_ok = 1'b0;
        endcase
        can_issue = !rst && head_valid && rs1_ok && rs2_ok && waw_ok && unit_ok;
        deq       = can_issue;
        alu_issue = can_issue && (head_exu_type == EXU_ALU);
        mul_issue = can_issue && (head_exu_type == EXU_MUL);
        div_issue = can_issue && (head_exu_type == EXU_DIV);
    end

    // Next-state for scoreboard, writeback reservations, divider and error flag
    always_comb begin
        busy_d = busy_q & ~clr_mask;
        if (can_issue && head_has_rd && (head_rd != 5'd0)) begin
            busy_d[head_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        // Type bits follow their valid bit so an idle slot never reads as MUL
        resv_d      = {1'b0, resv_q[MUL_LAT:1]};
        resv_type_d = {1'b0, resv_type_q[MUL_LAT:1] & resv_q[MUL_LAT:1]};
        if (alu_issue) begin
            resv_d[0]      = 1'b1;
            resv_type_d[0] = 1'b0;
        end
        if (mul_issue) begin
            resv_d[MUL_LAT-1]      = 1'b1;
            resv_type_d[MUL_LAT-1] = 1'b1;
        end

        div_busy_d = div_busy_q;
        if (div_issue) begin
            div_busy_d = 1'b1;
        end else if (div_wb_valid) begin
            div_busy_d = 1'b0;
        end

        err_bad_type_d = err_bad_type_q || (head_valid && (head_exu_type == EXU_MEM));
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q         <= '0;
            resv_q         <= '0;
            resv_type_q    <= '0;
            div_busy_q     <= 1'b0;
            err_bad_type_q <= 1'b0;
        end else begin
            busy_q         <= busy_d;
            resv_q         <= resv_d;
            resv_type_q    <= resv_type_d;
            div_busy_q     <= div_busy_d;
            err_bad_type_q <= err_bad_type_d;
        end
    end

    assign wb_port_valid  = resv_q[0];
    assign wb_port_is_mul = resv_type_q[0];
    assign err_bad_type   = err_bad_type_q;

endmodule

// File: tb/tb_alu_iq_issue_ctrl.sv
// tb/tb_alu_iq_issue_ctrl.sv - scoreboard testbench for alu_iq_issue_ctrl

module tb_alu_iq_issue_ctrl;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 17;
    localparam logic [1:0] T_ALU = 2'd0, T_MUL = 2'd1, T_DIV = 2'd2, T_MEM = 2'd3;
    // {alu, mul, div, deq}
    localparam logic [3:0] U_ALU = 4'b1001, U_MUL = 4'b0101, U_DIV = 4'b0011;
`ifdef ISSUE_WB_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    typedef struct {
        logic [1:0] t;
        logic       hrd, hrs1, hrs2;
        logic [4:0] rd, rs1, rs2;
    } op_t;
    typedef struct {
        int         c;
        logic [3:0] u;
    } ev_t;

    logic clk, rst;
    logic head_valid, head_has_rd, head_has_rs1, head_has_rs2;
    logic [1:0] head_exu_type;
    logic [4:0] head_rd, head_rs1, head_rs2;
    logic deq, alu_issue, mul_issue, div_issue, wb_port_valid, wb_port_is_mul;
    logic wb_valid, div_wb_valid, err_bad_type;
    logic [4:0] wb_rd, div_wb_rd;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    op_t op_q[$];
    ev_t exp_q[$];
    ev_t obs_q[$];
    logic [4:0] port_wb[int];
    logic [4:0] div_wb[int];
    logic wpv[int];
    logic wpm[int];

    alu_iq_issue_ctrl #(.MUL_LAT(MUL_LAT), .NUM_ARCH_REGS(32)) dut (
        .clk(clk), .rst(rst),
        .head_valid(head_valid), .head_exu_type(head_exu_type),
        .head_has_rd(head_has_rd), .head_has_rs1(head_has_rs1), .head_has_rs2(head_has_rs2),
        .head_rd(head_rd), .head_rs1(head_rs1), .head_rs2(head_rs2),
        .deq(deq), .alu_issue(alu_issue), .mul_issue(mul_issue), .div_issue(div_issue),
        .wb_port_valid(wb_port_valid), .wb_port_is_mul(wb_port_is_mul),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .div_wb_valid(div_wb_valid), .div_wb_rd(div_wb_rd),
        .err_bad_type(err_bad_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic op_t mk(logic [1:0] t, logic hrd, logic [4:0] rd,
                               logic hrs1, logic [4:0] rs1, logic hrs2, logic [4:0] rs2);
        op_t o;
        o.t = t; o.hrd = hrd; o.rd = rd; o.hrs1 = hrs1; o.rs1 = rs1; o.hrs2 = hrs2; o.rs2 = rs2;
        return o;
    endfunction

    // Drive head from the op queue and writebacks from the execution-unit model
    task automatic apply();
        if (op_q.size() != 0) begin
            head_valid = 1'b1;
            head_exu_type = op_q[0].t;
            head_has_rd = op_q[0].hrd; head_rd = op_q[0].rd;
            head_has_rs1 = op_q[0].hrs1; head_rs1 = op_q[0].rs1;
            head_has_rs2 = op_q[0].hrs2; head_rs2 = op_q[0].rs2;
        end else begin
            head_valid = 1'b0; head_exu_type = T_ALU;
            head_has_rd = 1'b0; head_has_rs1 = 1'b0; head_has_rs2 = 1'b0;
            head_rd = 5'd0; head_rs1 = 5'd0; head_rs2 = 5'd0;
        end
        wb_valid = 1'b0; wb_rd = 5'd0;
        if (port_wb.exists(cyc)) begin
            wb_valid = 1'b1; wb_rd = port_wb[cyc];
        end
        div_wb_valid = 1'b0; div_wb_rd = 5'd0;
        if (div_wb.exists(cyc)) begin
            div_wb_valid = 1'b1; div_wb_rd = div_wb[cyc];
        end
    endtask

    // Observe one cycle at the falling edge, then advance to the next cycle
    task automatic step();
        op_t o;
        @(negedge clk);
        wpv[cyc] = wb_port_valid;
        wpm[cyc] = wb_port_is_mul;
        if (deq || alu_issue || mul_issue || div_issue) begin
            obs_q.push_back('{c: cyc, u: {alu_issue, mul_issue, div_issue, deq}});
            if (op_q.size() != 0) begin
                o = op_q.pop_front();
                if (o.hrd) begin
                    if (alu_issue) port_wb[cyc + 1] = o.rd;
                    else if (mul_issue) port_wb[cyc + MUL_LAT] = o.rd;
                    else if (div_issue) div_wb[cyc + DIV_LAT] = o.rd;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        apply();
    endtask

    task automatic init();
        op_q.delete(); exp_q.delete(); obs_q.delete();
        port_wb.delete(); div_wb.delete();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        apply();
        @(posedge clk); #1; cyc++;
        @(posedge clk); #1; cyc++;
        rst = 1'b0;
        apply();
    endtask

    task automatic pop_obs(output ev_t o, output bit ok);
        ok = (obs_q.size() != 0);
        if (ok) o = obs_q.pop_front();
        else o = '{c: -1, u: 4'b0};
    endtask

    task automatic test_reset();
        init();
        rst = 1'b1;
        op_q.push_back(mk(T_ALU, 1, 5'd1, 0, 5'd0, 0, 5'd0));
        apply();
        #2;
        total++;
        if ({deq, alu_issue, mul_issue, div_issue, wb_port_valid, wb_port_is_mul, err_bad_type} !== 7'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0000000",
                     {deq, alu_issue, mul_issue, div_issue, wb_port_valid, wb_port_is_mul, err_bad_type});
        end
        @(posedge clk); #1; cyc++;
        total++;
        if ({deq, alu_issue, wb_port_valid, err_bad_type} !== 4'b0) begin
            bad++;
            $display("FAIL reset_held: got %b want 0000", {deq, alu_issue, wb_port_valid, err_bad_type});
        end
    endtask

    task automatic test_raw();
        ev_t e, o; bit ok; int b;
        init(); reset_dut();
        op_q.push_back(mk(T_ALU, 1, 5'd1, 0, 5'd0, 0, 5'd0));
        op_q.push_back(mk(T_ALU, 1, 5'd2, 1, 5'd1, 1, 5'd0));
        apply(); b = cyc;
        exp_q.push_back('{c: b, u: U_ALU});
        exp_q.push_back('{c: b + 2 - BYP, u: U_ALU});
        repeat (5) step();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); pop_obs(o, ok); total++;
            if (!ok || o.c !== e.c || o.u !== e.u) begin
                bad++; $display("FAIL raw_issue: got c=%0d u=%b want c=%0d u=%b", o.c - b, o.u, e.c - b, e.u);
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL raw_extra: got %0d extra issues want 0", obs_q.size()); end
        total++;
        if (wpv[b + 1] !== 1'b1) begin bad++; $display("FAIL raw_wb_port: got %b want 1", wpv[b + 1]); end
    endtask

    task automatic test_mul_collision();
        ev_t e, o; bit ok; int b;
        init(); reset_dut();
        op_q.push_back(mk(T_MUL, 1, 5'd3, 0, 5'd0, 0, 5'd0));
        op_q.push_back(mk(T_ALU, 1, 5'd4, 0, 5'd0, 0, 5'd0));
        op_q.push_back(mk(T_ALU, 1, 5'd5, 0, 5'd0, 0, 5'd0));
        apply(); b = cyc;
        exp_q.push_back('{c: b, u: U_MUL});
        exp_q.push_back('{c: b + 1, u: U_ALU});
        exp_q.push_back('{c: b + 3, u: U_ALU});
        repeat (7) step();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); pop_obs(o, ok); total++;
            if (!ok || o.c !== e.c || o.u !== e.u) begin
                bad++; $display("FAIL mul_issue: got c=%0d u=%b want c=%0d u=%b", o.c - b, o.u, e.c - b, e.u);
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL mul_extra: got %0d extra issues want 0", obs_q.size()); end
        for (int k = 0; k < 6; k++) begin
            total++;
            if (wpm[b + k] !== (k == 3) || wpv[b + k] !== (k >= 2 && k <= 4)) begin
                bad++;
                $display("FAIL mul_wb_port t%0d: got valid=%b is_mul=%b want valid=%b is_mul=%b",
                         k, wpv[b + k], wpm[b + k], (k >= 2 && k <= 4), (k == 3));
            end
        end
    endtask

    task automatic test_div();
        ev_t e, o; bit ok; int b;
        init(); reset_dut();
        op_q.push_back(mk(T_DIV, 1, 5'd6, 0, 5'd0, 0, 5'd0));
        op_q.push_back(mk(T_DIV, 1, 5'd7, 0, 5'd0, 0, 5'd0));
        op_q.push_back(mk(T_DIV, 1, 5'd9, 0, 5'd0, 0, 5'd0));
        apply(); b = cyc;
        exp_q.push_back('{c: b, u: U_DIV});
        exp_q.push_back('{c: b + DIV_LAT, u: U_DIV});
        exp_q.push_back('{c: b + 2 * DIV_LAT, u: U_DIV});
        repeat (2 * DIV_LAT + 3) step();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); pop_obs(o, ok); total++;
            if (!ok || o.c !== e.c || o.u !== e.u) begin
                bad++; $display("FAIL div_issue: got c=%0d u=%b want c=%0d u=%b", o.c - b, o.u, e.c - b, e.u);
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL div_extra: got %0d extra issues want 0", obs_q.size()); end
    endtask

    task automatic test_waw();
        ev_t e, o; bit ok; int b;
        init(); reset_dut();
        op_q.push_back(mk(T_MUL, 1, 5'd5, 0, 5'd0, 0, 5'd0));
        op_q.push_back(mk(T_ALU, 1, 5'd5, 0, 5'd0, 0, 5'd0));
        op_q.push_back(mk(T_ALU, 1, 5'd10, 1, 5'd5, 0, 5'd0));
        apply(); b = cyc;
        exp_q.push_back('{c: b, u: U_MUL});
        exp_q.push_back('{c: b + 4 - BYP, u: U_ALU});
        exp_q.push_back('{c: b + 6 - 2 * BYP, u: U_ALU});
        repeat (8) step();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); pop_obs(o, ok); total++;
            if (!ok || o.c !== e.c || o.u !== e.u) begin
                bad++; $display("FAIL waw_issue: got c=%0d u=%b want c=%0d u=%b", o.c - b, o.u, e.c - b, e.u);
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL waw_extra: got %0d extra issues want 0", obs_q.size()); end
    endtask

    task automatic test_back_to_back();
        ev_t e, o; bit ok; int b;
        init(); reset_dut();
        op_q.push_back(mk(T_ALU, 1, 5'd0, 1, 5'd0, 0, 5'd0));
        op_q.push_back(mk(T_ALU, 1, 5'd8, 1, 5'd0, 1, 5'd0));
        op_q.push_back(mk(T_ALU, 1, 5'd0, 1, 5'd0, 0, 5'd0));
        for (int i = 0; i < 4; i++) op_q.push_back(mk(T_ALU, 1, 5'(20 + i), 0, 5'd0, 0, 5'd0));
        apply(); b = cyc;
        for (int i = 0; i < 7; i++) exp_q.push_back('{c: b + i, u: U_ALU});
        repeat (9) step();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); pop_obs(o, ok); total++;
            if (!ok || o.c !== e.c || o.u !== e.u) begin
                bad++; $display("FAIL b2b_issue: got c=%0d u=%b want c=%0d u=%b", o.c - b, o.u, e.c - b, e.u);
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL b2b_extra: got %0d extra issues want 0", obs_q.size()); end
    endtask

    task automatic test_bad_type();
        init(); reset_dut();
        total++;
        if (err_bad_type !== 1'b0) begin bad++; $display("FAIL err_initial: got %b want 0", err_bad_type); end
        op_q.push_back(mk(T_MEM, 1, 5'd12, 0, 5'd0, 0, 5'd0));
        apply();
        repeat (3) step();
        total++;
        if (err_bad_type !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", err_bad_type); end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL mem_deq: got %0d issues want 0", obs_q.size()); end
        op_q.delete(); apply();
        repeat (2) step();
        total++;
        if (err_bad_type !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err_bad_type); end
    endtask

    task automatic test_reset_mid_div();
        ev_t e, o; bit ok; int b, r;
        init(); reset_dut();
        op_q.push_back(mk(T_DIV, 1, 5'd6, 0, 5'd0, 0, 5'd0));
        op_q.push_back(mk(T_MUL, 1, 5'd11, 0, 5'd0, 0, 5'd0));
        op_q.push_back(mk(T_ALU, 1, 5'd14, 0, 5'd0, 0, 5'd0));
        op_q.push_back(mk(T_ALU, 1, 5'd12, 1, 5'd6, 0, 5'd0));
        apply(); b = cyc;
        exp_q.push_back('{c: b, u: U_DIV});
        exp_q.push_back('{c: b + 1, u: U_MUL});
        exp_q.push_back('{c: b + 2, u: U_ALU});
        repeat (3) step();
        total++;
        if (wb_port_valid !== 1'b1) begin bad++; $display("FAIL pre_rst_wb: got %b want 1", wb_port_valid); end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({deq, alu_issue, mul_issue, div_issue, wb_port_valid, wb_port_is_mul, err_bad_type} !== 7'b0) begin
            bad++;
            $display("FAIL async_rst: got %b want 0000000",
                     {deq, alu_issue, mul_issue, div_issue, wb_port_valid, wb_port_is_mul, err_bad_type});
        end
        @(posedge clk); #1; cyc++;
        rst = 1'b0;
        op_q.push_back(mk(T_DIV, 1, 5'd13, 0, 5'd0, 0, 5'd0));
        apply(); r = cyc;
        exp_q.push_back('{c: r, u: U_ALU});
        exp_q.push_back('{c: r + 1, u: U_DIV});
        repeat (4) step();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); pop_obs(o, ok); total++;
            if (!ok || o.c !== e.c || o.u !== e.u) begin
                bad++; $display("FAIL rst_mid_issue: got c=%0d u=%b want c=%0d u=%b", o.c - b, o.u, e.c - b, e.u);
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL rst_mid_extra: got %0d extra issues want 0", obs_q.size()); end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_mul_collision();
        test_div();
        test_waw();
        test_back_to_back();
        test_bad_type();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
